// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl: sequencer for a bank of T flip-flops used as a binary counter.
// It clears the bank, enables toggling until the fed-back count matches the
// latched limit, pulses done and counts the enabled cycles in ticks.
// Optional macro TFF_SEQ_DOWN_EN: when defined, dir_down selects a down count;
// when undefined, dir_down is ignored and the bank always counts up.
module tff_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t_en,
    output logic             tff_reset,
    output logic             busy,
    output logic             done,
    output logic [7:0]       ticks
);

    localparam int unsigned TICK_W   = 8;
    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic               dir_q, dir_d;
    logic [TICK_W-1:0]  ticks_q, ticks_d;

    logic               dir_sel;
    logic [WIDTH-1:0]   t_raw;
    logic               terminal;

`ifdef TFF_SEQ_DOWN_EN
    // Direction request is honoured and latched at start.
    assign dir_sel = dir_down;
`else
    // Up-count-only build: the direction port stays but has no effect.
    logic unused_dir_down;
    assign unused_dir_down = dir_down;
    assign dir_sel         = 1'b0;
`endif

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down); bit 0 always toggles.
    always_comb begin
        logic and_acc;
        logic nor_acc;
        and_acc = 1'b1;
        nor_acc = 1'b1;
        t_raw   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t_raw[i] = dir_q ? nor_acc : and_acc;
            and_acc  = and_acc & q_in[i];
            nor_acc  = nor_acc & ~q_in[i];
        end
    end

    // Terminal count when the bank output equals the latched limit.
    assign terminal = (q_in == limit_q);

    // State and latched-parameter registers; reset returns to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            limit_q <= '0;
            dir_q   <= 1'b0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            ticks_q <= ticks_d;
        end
    end

    // Next-state, latch control and toggle-enable gating.
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        ticks_d = ticks_q;
        t_en    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_CLEAR;
                    limit_d = limit;
                    dir_d   = dir_sel;
                    ticks_d = '0;
                end
            end
            S_CLEAR: begin
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (terminal) begin
                    state_d = S_DONE;
                end else begin
                    t_en = t_raw;
                    if (ticks_q != TICK_MAX) begin
                        ticks_d = ticks_q + TICK_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decoded from the state register; bank reset also follows reset.
    assign tff_reset = reset | (state_q == S_CLEAR);
    assign busy      = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign ticks     = ticks_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Bench for tff_seq_ctrl with a behavioural T flip-flop bank closing the loop.
// Expected count sequences come from an arithmetic +1/-1 model pushed to a
// scoreboard queue at start and popped once per RUN cycle.
module tb_tff_seq_ctrl;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] t;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic [W-1:0] limit;
    logic         dir_down;
    logic [W-1:0] q_in;
    logic [W-1:0] t_en;
    logic         tff_reset;
    logic         busy;
    logic         done;
    logic [7:0]   ticks;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    tff_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .limit     (limit),
        .dir_down  (dir_down),
        .q_in      (q_in),
        .t_en      (t_en),
        .tff_reset (tff_reset),
        .busy      (busy),
        .done      (done),
        .ticks     (ticks)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // T flip-flop bank with asynchronous clear.
    always_ff @(posedge clk or posedge tff_reset) begin
        if (tff_reset) q_in <= '0;
        else           q_in <= q_in ^ t_en;
    end

    // Model: push one entry per expected RUN cycle (q seen, t_en expected).
    task automatic push_run(input int lim, input bit down, input int stop_at,
                            output int exp_ticks);
        logic [W-1:0] q;
        logic [W-1:0] nq;
        bit dn;
`ifdef TFF_SEQ_DOWN_EN
        dn = down;
`else
        dn = 1'b0;
`endif
        q = '0;
        exp_ticks = 0;
        for (int k = 1; k <= 40; k++) begin
            if (stop_at == k || q == W'(lim)) begin
                sb.push_back(exp_t'{q: q, t: '0});
                break;
            end
            nq = dn ? q - W'(1) : q + W'(1);
            sb.push_back(exp_t'{q: q, t: q ^ nq});
            exp_ticks++;
            q = nq;
        end
    endtask

    // Stimulus only: pulse start; returns at the negedge of the CLEAR cycle.
    task automatic start_seq(input int lim, input bit down);
        @(negedge clk);
        start    = 1'b1;
        limit    = W'(lim);
        dir_down = down;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({t_en, tff_reset, busy, done, ticks} !== {4'h0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: t_en=%h tff_reset=%b busy=%b done=%b ticks=%0d, expected 0/1/0/0/0",
                     t_en, tff_reset, busy, done, ticks);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tff_reset, busy, done, q_in} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_release: tff_reset=%b busy=%b done=%b q_in=%h, expected 0/0/0/0",
                     tff_reset, busy, done, q_in);
        end
    endtask

    task automatic test_up();
        int et;
        int n;
        exp_t e;
        push_run(5, 1'b0, 0, et);
        start_seq(5, 1'b0);
        checks++;
        if ({busy, tff_reset, t_en} !== {1'b1, 1'b1, 4'h0}) begin
            errors++;
            $display("FAIL up_clear: busy=%b tff_reset=%b t_en=%h, expected 1/1/0", busy, tff_reset, t_en);
        end
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, tff_reset, done, q_in, t_en} !== {1'b1, 1'b0, 1'b0, e.q, e.t}) begin
                errors++;
                $display("FAIL up_run%0d: busy=%b q_in=%h t_en=%h, expected busy=1 q_in=%h t_en=%h",
                         n, busy, q_in, t_en, e.q, e.t);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done, ticks, q_in} !== {1'b0, 1'b1, 8'd5, 4'd5}) begin
            errors++;
            $display("FAIL up_done: busy=%b done=%b ticks=%0d q_in=%0d, expected 0/1/5/5", busy, done, ticks, q_in);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, ticks} !== {1'b0, 1'b0, 8'(et)}) begin
            errors++;
            $display("FAIL up_idle: busy=%b done=%b ticks=%0d, expected 0/0/%0d", busy, done, ticks, et);
        end
    endtask

    task automatic test_start_stop_idle();
        logic [7:0] t0;
        t0 = ticks;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        limit = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, tff_reset, done, ticks} !== {1'b0, 1'b0, 1'b0, t0}) begin
                errors++;
                $display("FAIL start_stop_idle%0d: busy=%b tff_reset=%b done=%b ticks=%0d, expected 0/0/0/%0d",
                         i, busy, tff_reset, done, ticks, t0);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_limit_zero();
        int et;
        int n;
        exp_t e;
        push_run(0, 1'b0, 0, et);
        start_seq(0, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, q_in, t_en} !== {1'b1, e.q, e.t}) begin
                errors++;
                $display("FAIL zero_run%0d: busy=%b q_in=%h t_en=%h, expected 1/%h/%h", n, busy, q_in, t_en, e.q, e.t);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, ticks, t_en} !== {1'b1, 1'b0, 8'd0, 4'h0}) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b ticks=%0d t_en=%h, expected 1/0/0/0", done, busy, ticks, t_en);
        end
    endtask

    task automatic test_abort();
        int et;
        int n;
        exp_t e;
        push_run(12, 1'b0, 4, et);
        start_seq(12, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            if (n == 3) begin
                stop = 1'b1;
                #1;
            end
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, q_in, t_en} !== {1'b1, e.q, e.t}) begin
                errors++;
                $display("FAIL abort_run%0d: busy=%b q_in=%h t_en=%h, expected 1/%h/%h", n, busy, q_in, t_en, e.q, e.t);
            end
        end
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({busy, done, q_in, ticks} !== {1'b0, 1'b0, 4'd3, 8'd3}) begin
            errors++;
            $display("FAIL abort_after: busy=%b done=%b q_in=%0d ticks=%0d, expected 0/0/3/3", busy, done, q_in, ticks);
        end
        @(negedge clk);
        checks++;
        if ({done, ticks} !== {1'b0, 8'(et)}) begin
            errors++;
            $display("FAIL abort_no_done: done=%b ticks=%0d, expected 0/%0d", done, ticks, et);
        end
    endtask

    task automatic test_start_ignored();
        int et;
        int n;
        exp_t e;
        push_run(3, 1'b0, 0, et);
        start_seq(3, 1'b0);
        start = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, tff_reset, q_in, t_en} !== {1'b1, 1'b0, e.q, e.t}) begin
                errors++;
                $display("FAIL ignore_run%0d: busy=%b tff_reset=%b q_in=%h t_en=%h, expected 1/0/%h/%h",
                         n, busy, tff_reset, q_in, t_en, e.q, e.t);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, ticks} !== {1'b1, 1'b0, 8'(et)}) begin
            errors++;
            $display("FAIL ignore_done: done=%b busy=%b ticks=%0d, expected 1/0/%0d", done, busy, ticks, et);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, tff_reset} !== {1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_in_done: done=%b busy=%b tff_reset=%b, expected 0/0/0", done, busy, tff_reset);
        end
        @(negedge clk);
        checks++;
        if ({busy, tff_reset} !== {1'b1, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back_clear: busy=%b tff_reset=%b, expected 1/1", busy, tff_reset);
        end
        start = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        checks++;
        if ({busy, tff_reset, done, ticks} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clear_stop: busy=%b tff_reset=%b done=%b ticks=%0d, expected 0/0/0/0",
                     busy, tff_reset, done, ticks);
        end
    endtask

    task automatic test_down();
        int et;
        int n;
        exp_t e;
        push_run(13, 1'b1, 0, et);
        start_seq(13, 1'b1);
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, q_in, t_en} !== {1'b1, e.q, e.t}) begin
                errors++;
                $display("FAIL down_run%0d: busy=%b q_in=%h t_en=%h, expected 1/%h/%h", n, busy, q_in, t_en, e.q, e.t);
            end
        end
        @(negedge clk);
        checks++;
`ifdef TFF_SEQ_DOWN_EN
        if ({done, ticks, q_in} !== {1'b1, 8'd3, 4'd13}) begin
            errors++;
            $display("FAIL down_done: done=%b ticks=%0d q_in=%0d, expected 1/3/13", done, ticks, q_in);
        end
`else
        if ({done, ticks, q_in} !== {1'b1, 8'd13, 4'd13}) begin
            errors++;
            $display("FAIL down_ignored_done: done=%b ticks=%0d q_in=%0d, expected 1/13/13", done, ticks, q_in);
        end
`endif
        dir_down = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int et;
        int n;
        exp_t e;
        push_run(9, 1'b0, 0, et);
        start_seq(9, 1'b0);
        n = 0;
        while (sb.size() > 0 && n < 3) begin
            @(negedge clk);
            e = sb.pop_front();
            n++;
            checks++;
            if ({busy, q_in, t_en} !== {1'b1, e.q, e.t}) begin
                errors++;
                $display("FAIL rst_run%0d: busy=%b q_in=%h t_en=%h, expected 1/%h/%h", n, busy, q_in, t_en, e.q, e.t);
            end
        end
        sb.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({t_en, tff_reset, busy, done, ticks, q_in} !== {4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 4'h0}) begin
            errors++;
            $display("FAIL rst_async: t_en=%h tff_reset=%b busy=%b done=%b ticks=%0d q_in=%h, expected 0/1/0/0/0/0",
                     t_en, tff_reset, busy, done, ticks, q_in);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, tff_reset, t_en} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
                errors++;
                $display("FAIL rst_after%0d: busy=%b done=%b tff_reset=%b t_en=%h, expected 0/0/0/0",
                         i, busy, done, tff_reset, t_en);
            end
        end
    endtask

    initial begin
        start    = 1'b0;
        stop     = 1'b0;
        limit    = '0;
        dir_down = 1'b0;
        reset    = 1'b0;
        test_reset();
        test_up();
        test_start_stop_idle();
        test_limit_zero();
        test_abort();
        test_start_ignored();
        test_down();
        test_reset_mid_run();
        test_up();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
